cache_wb_serializer: RTL

- Cache writeback engine. It takes one evicted dirty cache block (8 x 16-bit words) and serializes it word-by-word to the memory write port under a valid/ready handshake.
- It is the read-out counterpart of the cache fill path. The fill path maps a word offset to a one-hot word enable. This block walks word offsets 0..7, and for each one emits the binary index, the one-hot select and the byte address.
- It sits between the cache data array and the memory interface and is driven by the cache controller FSM.

---
 rtl/cache_wb_serializer_pkg.sv | 22 ++
 rtl/cache_wb_serializer_if.sv | 20 ++
 rtl/cache_wb_serializer_word_decoder.sv | 21 ++
 rtl/cache_wb_serializer.sv | 83 ++++++++
 4 files changed

// File: rtl/cache_wb_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_wb_serializer_pkg
// Brief    : Shared cache constants and writeback FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package cache_wb_serializer_pkg;

  localparam int WORD_W     = 16;               // data word width
  localparam int NUM_WORDS  = 8;                // words per cache block
  localparam int ADDR_W     = 16;               // byte address width
  localparam int BLK_W      = NUM_WORDS * WORD_W;
  localparam int OFFSET_W   = 3;                // word offset inside a block
  localparam int BYTE_OFF_W = OFFSET_W + 1;     // byte offset inside a block

  // Writeback FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/cache_wb_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_wb_serializer_if
// Brief    : Memory write port (valid/ready) between writeback engine and
//            memory controller.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_wb_serializer_if;
  import cache_wb_serializer_pkg::*;

  logic              wr_en;   // write request valid
  logic [ADDR_W-1:0] addr;    // byte address of current word
  logic [WORD_W-1:0] wdata;   // current word
  logic              ready;   // memory accepts current word this cycle

  modport master (output wr_en, addr, wdata, input ready);
  modport slave  (input wr_en, addr, wdata, output ready);

endinterface
`default_nettype wire

// File: rtl/cache_wb_serializer_word_decoder.sv
`default_nettype none
// ============================================================================
// Module   : word_decoder
// Brief    : 3-to-8 word-offset decoder with enable; produces a one-hot word
//            select, all-zero when disabled.
// Revision : 1.0 - initial release
// ============================================================================
module word_decoder
  import cache_wb_serializer_pkg::*;
(
  input  logic                 en,
  input  logic [OFFSET_W-1:0]  idx,
  output logic [NUM_WORDS-1:0] sel
);

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_sel
    assign sel[k] = en && (idx == OFFSET_W'(k));
  end

endmodule
`default_nettype wire

// File: rtl/cache_wb_serializer.sv
`default_nettype none
// ============================================================================
// Module   : cache_wb_serializer
// Brief    : Cache writeback engine. Captures one dirty block and streams its
//            eight words to the memory write port under valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module cache_wb_serializer
  import cache_wb_serializer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     blk_addr,
  input  logic [BLK_W-1:0]      blk_data,
  output logic                  busy,
  output logic                  done,
  output logic [OFFSET_W-1:0]   word_idx,
  output logic [NUM_WORDS-1:0]  word_sel,
  cache_wb_serializer_if.master mem
);

  logic [1:0]               r_state;
  logic [OFFSET_W-1:0]      r_idx;
  logic [BLK_W-1:0]         r_data;
  logic [ADDR_W-BYTE_OFF_W-1:0] r_base_hi;   // block-aligned part of the address
  logic                     w_send;
  logic                     w_unused_addr_lsb;

  // The byte offset of the requested address is irrelevant: the whole block goes out.
  assign w_unused_addr_lsb = ^blk_addr[BYTE_OFF_W-1:0];

  assign w_send = (r_state == ST_SEND);

  // FSM, word counter and block/address capture; only IDLE listens to start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_data    <= '0;
      r_base_hi <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_SEND;
            r_data    <= blk_data;
            r_base_hi <= blk_addr[ADDR_W-1:BYTE_OFF_W];
            r_idx     <= '0;
          end
        end
        ST_SEND: begin
          if (mem.ready) begin
            // Natural 3-bit wrap returns the counter to 0 after the last word.
            r_idx <= r_idx + 1'b1;
            if (r_idx == OFFSET_W'(NUM_WORDS - 1)) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state, so ready never reaches them combinationally.
  // The word offset is concatenated below the base: no carry into the block address.
  assign mem.wr_en = w_send;
  assign mem.addr  = w_send ? {r_base_hi, r_idx, 1'b0} : '0;
  assign mem.wdata = w_send ? r_data[int'(r_idx) * WORD_W +: WORD_W] : '0;
  assign word_idx  = w_send ? r_idx : '0;
  assign busy      = w_send || (r_state == ST_DONE);
  assign done      = (r_state == ST_DONE);

  word_decoder u_word_decoder (
    .en  (w_send),
    .idx (r_idx),
    .sel (word_sel)
  );

endmodule
`default_nettype wire
